// File: rtl/router_slice_pkg.sv
// router_slice_pkg: shared types and constants for the router output slice.
// Holds the per-channel state encoding and the stall-counter saturation value.
package router_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    // Widest supported stall counter; a channel slices its own
    // saturation value out of this all-ones constant.
    localparam int CNT_W_MAX = 64;
    localparam logic [CNT_W_MAX-1:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/router_skid_ch.sv
// router_skid_ch: one channel of the output slice, a registered valid/ready
// stage with a 2-entry skid buffer (main + skid) and synchronous flush.
// Ports: clk, reset_n (async low), cfg_flush, in_valid/in_data/in_ready
// (upstream), out_valid/out_data/out_ready (downstream).
// ROUTER_SLICE_STATS_EN adds stat_clr and a saturating stall_cnt.
module router_skid_ch
    import router_slice_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef ROUTER_SLICE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
`ifdef ROUTER_SLICE_STATS_EN
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    input  logic              out_ready
);

    slice_state_e      state_q;
    slice_state_e      state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              rdy_q;
    logic              accept;
    logic              take;

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & rdy_q;
    assign take      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (cfg_flush) begin
            // Flush overrides any accept/take this cycle.
            state_d = EMPTY;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    case ({accept, take})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (take) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            // Ready looks ahead at the next state so it stays registered.
            rdy_q   <= (state_d != FULL);
        end
    end

`ifdef ROUTER_SLICE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_SAT_ALL[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q;

    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (stat_clr) begin
            cnt_q <= '0;
        end else if (out_valid && !out_ready && cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/router_ovalid_slice.sv
// router_ovalid_slice: NUM_CH independent registered valid/ready slices
// between crossbar outputs and tile pins. Ports: clk, reset_n, cfg_flush,
// in_valid/in_data/in_ready, out_valid/out_data/out_ready (ch i at
// [i*DATA_W +: DATA_W]). ROUTER_SLICE_STATS_EN adds stat_clr, stall_cnt.
module router_ovalid_slice
    import router_slice_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_flush,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
`ifdef ROUTER_SLICE_STATS_EN
    input  logic                     stat_clr,
    output logic [NUM_CH*CNT_W-1:0]  stall_cnt,
`endif
    input  logic [NUM_CH-1:0]        out_ready
);

    if (NUM_CH < 1 || DATA_W < 1 || CNT_W < 1 ||
        CNT_W > CNT_W_MAX) begin : g_bad_param
        $error("router_ovalid_slice: bad parameters");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_skid_ch #(
            .DATA_W    (DATA_W)
`ifdef ROUTER_SLICE_STATS_EN
            ,
            .CNT_W     (CNT_W)
`endif
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .cfg_flush (cfg_flush),
            .in_valid  (in_valid[i]),
            .in_data   (in_data[i*DATA_W +: DATA_W]),
            .in_ready  (in_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*DATA_W +: DATA_W]),
`ifdef ROUTER_SLICE_STATS_EN
            .stat_clr  (stat_clr),
            .stall_cnt (stall_cnt[i*CNT_W +: CNT_W]),
`endif
            .out_ready (out_ready[i])
        );
    end

endmodule

// File: tb/tb_router_ovalid_slice.sv
// tb_router_ovalid_slice: directed bench for router_ovalid_slice.
// Covers reset, streaming, backpressure, flush, independence, async reset.
module tb_router_ovalid_slice;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 4;

    logic            clk;
    logic            reset_n;
    logic            cfg_flush;
    logic [NCH-1:0]  in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]  in_ready;
    logic [NCH-1:0]  out_valid;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]  out_ready;
`ifdef ROUTER_SLICE_STATS_EN
    logic            stat_clr;
    logic [NCH*CW-1:0] stall_cnt;
`endif

    int passed = 0;
    int total  = 0;

    router_ovalid_slice #(
        .NUM_CH    (NCH),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_flush (cfg_flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef ROUTER_SLICE_STATS_EN
        .stat_clr  (stat_clr),
        .stall_cnt (stall_cnt),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic put(input int ch, input logic [DW-1:0] v);
        in_data[ch*DW +: DW] = v;
        in_valid[ch] = 1'b1;
    endtask

    function automatic logic [DW-1:0] od(input int ch);
        return out_data[ch*DW +: DW];
    endfunction

    initial begin
        reset_n   = 1'b0;
        cfg_flush = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
`ifdef ROUTER_SLICE_STATS_EN
        stat_clr  = 1'b0;
`endif
        // 1: reset and release
        #2;
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_irdy", 32'(in_ready), 32'h0);
        chk("rst_odata", out_data, 32'h0);
        tick();
        chk("rst_irdy_edge", 32'(in_ready), 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rel_irdy_pre", 32'(in_ready), 32'h0);
        tick();
        chk("rel_irdy", 32'(in_ready), 32'hF);
        chk("rel_ovalid", 32'(out_valid), 32'h0);

        // 2: streaming ch0
        out_ready = 4'hF;
        for (int k = 0; k < 8; k++) begin
            put(0, 8'(k));
            tick();
            chk("str_ov", 32'(out_valid[0]), 32'h1);
            chk("str_od", 32'(od(0)), 32'(k));
            chk("str_ir", 32'(in_ready[0]), 32'h1);
        end
        in_valid = '0;
        tick();
        chk("str_drain", 32'(out_valid[0]), 32'h0);

        // 3: backpressure ch1
        out_ready[1] = 1'b0;
        put(1, 8'hA1);
        tick();
        chk("bp_ov1", 32'(out_valid[1]), 32'h1);
        chk("bp_ir1", 32'(in_ready[1]), 32'h1);
        put(1, 8'hA2);
        tick();
        chk("bp_full_ir", 32'(in_ready[1]), 32'h0);
        chk("bp_od_a1", 32'(od(1)), 32'hA1);
        in_valid = '0;
        out_ready[1] = 1'b1;
        tick();
        chk("bp_od_a2", 32'(od(1)), 32'hA2);
        chk("bp_ov_a2", 32'(out_valid[1]), 32'h1);
        chk("bp_ir_back", 32'(in_ready[1]), 32'h1);
        tick();
        chk("bp_empty", 32'(out_valid[1]), 32'h0);

        // 4: flush with ch2 full
        out_ready[2] = 1'b0;
        put(2, 8'hC1);
        tick();
        put(2, 8'hC2);
        tick();
        chk("fl_full", 32'(in_ready[2]), 32'h0);
        cfg_flush = 1'b1;
        put(2, 8'hBB);
        tick();
        chk("fl_ov", 32'(out_valid[2]), 32'h0);
        chk("fl_ir", 32'(in_ready[2]), 32'h1);
        tick();
        chk("fl_drop_bb", 32'(out_valid[2]), 32'h0);
        cfg_flush = 1'b0;
        in_valid  = '0;
        out_ready[2] = 1'b1;
        tick();
        chk("fl_after", 32'(out_valid[2]), 32'h0);
        chk("fl_ir_after", 32'(in_ready[2]), 32'h1);

        // 5: independence and async reset
        out_ready[3] = 1'b0;
        put(3, 8'hD1);
        put(0, 8'h10);
        tick();
        chk("ind_ov3", 32'(out_valid[3]), 32'h1);
        chk("ind_od0", 32'(od(0)), 32'h10);
        in_valid[3] = 1'b0;
        for (int k = 1; k < 3; k++) begin
            put(0, 8'(8'h10 + k));
            tick();
            chk("ind_ch0", 32'(od(0)), 32'(8'h10 + k));
            chk("ind_ch0v", 32'(out_valid[0]), 32'h1);
            chk("ind_ch3", 32'(od(3)), 32'hD1);
        end
        reset_n = 1'b0;
        #1;
        chk("arst_ov", 32'(out_valid), 32'h0);
        chk("arst_ir", 32'(in_ready), 32'h0);
        chk("arst_od", out_data, 32'h0);
        in_valid = '0;
        #2;
        reset_n = 1'b1;
        tick();
        chk("arst_rel", 32'(in_ready), 32'hF);
        chk("arst_rel_ov", 32'(out_valid), 32'h0);

`ifdef ROUTER_SLICE_STATS_EN
        // 6: stall counter
        out_ready = '0;
        put(0, 8'hE1);
        tick();
        chk("st_start", 32'(stall_cnt[3:0]), 32'h0);
        in_valid = '0;
        repeat (10) tick();
        chk("st_10", 32'(stall_cnt[3:0]), 32'd10);
        chk("st_ch1", 32'(stall_cnt[7:4]), 32'd0);
        repeat (10) tick();
        chk("st_sat", 32'(stall_cnt[3:0]), 32'd15);
        stat_clr = 1'b1;
        tick();
        chk("st_clr", 32'(stall_cnt[3:0]), 32'd0);
        stat_clr = 1'b0;
        tick();
        chk("st_resume", 32'(stall_cnt[3:0]), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
